// File: rtl/ltc_biphase_serializer.sv
// Biphase-mark (LTC) serializer: shifts an 80-bit timecode word out LSB first,
// with a one-word holding register so back-to-back frames leave no gap.
module ltc_biphase_serializer #(
    parameter int unsigned HALF_BIT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [79:0] tc_data,
    input  logic        tc_valid,
    output logic        tc_ready,
    output logic        ltc_out,
    output logic        frame_start,
    output logic [6:0]  bit_idx,
    output logic        busy,
    output logic        underrun
);

    localparam int unsigned FRAME_BITS = 80;
    localparam int unsigned DIV_W      = (HALF_BIT_CYCLES > 2) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_BIT_CYCLES - 1);
    localparam logic [6:0]       LAST_BIT = 7'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   hold_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    hold_valid;
    logic [DIV_W-1:0]        divider;
    logic                    half;
    logic                    accept;
    logic                    half_end;

    // Ready depends only on the holding register, so a transfer cycle never accepts.
    assign tc_ready = ~hold_valid & rst_n;
    assign accept   = tc_valid & tc_ready;
    assign half_end = (divider == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_reg    <= '0;
            shift_reg   <= '0;
            hold_valid  <= 1'b0;
            divider     <= '0;
            half        <= 1'b0;
            ltc_out     <= 1'b0;
            bit_idx     <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (accept) begin
                hold_reg   <= tc_data;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        shift_reg   <= hold_reg;
                        hold_valid  <= 1'b0;
                        bit_idx     <= '0;
                        half        <= 1'b0;
                        divider     <= '0;
                        ltc_out     <= ~ltc_out;
                        frame_start <= 1'b1;
                        state       <= RUN;
                        busy        <= 1'b1;
                    end
                end

                RUN: begin
                    if (!half_end) begin
                        divider <= divider + DIV_W'(1);
                    end else begin
                        divider <= '0;
                        if (!half) begin
                            // Mid-cell transition encodes a 1.
                            if (shift_reg[0]) begin
                                ltc_out <= ~ltc_out;
                            end
                            half <= 1'b1;
                        end else if (bit_idx != LAST_BIT) begin
                            ltc_out   <= ~ltc_out;
                            shift_reg <= {1'b0, shift_reg[FRAME_BITS-1:1]};
                            bit_idx   <= bit_idx + 7'd1;
                            half      <= 1'b0;
                        end else if (hold_valid) begin
                            // Seamless frame boundary: the transfer supplies the cell-edge toggle.
                            shift_reg   <= hold_reg;
                            hold_valid  <= 1'b0;
                            bit_idx     <= '0;
                            half        <= 1'b0;
                            ltc_out     <= ~ltc_out;
                            frame_start <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            underrun <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltc_biphase_serializer.sv
// Bench for ltc_biphase_serializer: frame-level reference model compared every
// cycle, plus directed literal checks of toggle timing and frame spacing.
module tb_ltc_biphase_serializer;

    localparam int H     = 4;
    localparam int CELL  = 2 * H;
    localparam int FRAME = 80 * CELL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [79:0] tc_data = '0;
    logic        tc_valid = 1'b0;
    logic        tc_ready;
    logic        ltc_out;
    logic        frame_start;
    logic [6:0]  bit_idx;
    logic        busy;
    logic        underrun;

    ltc_biphase_serializer #(.HALF_BIT_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .tc_data(tc_data), .tc_valid(tc_valid),
        .tc_ready(tc_ready), .ltc_out(ltc_out), .frame_start(frame_start),
        .bit_idx(bit_idx), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: line level is the start level XOR the parity of the
    // number of transitions (frame start, cell edges, mid-cell ones) so far.
    function automatic bit level_at(input logic [79:0] w, input bit base, input int k);
        int n;
        n = 1 + k / CELL;
        for (int c = 0; c < 80; c++)
            if (w[c] && (c * CELL + H <= k)) n++;
        return base ^ n[0];
    endfunction

    bit          m_run = 0, m_hv = 0, m_fs = 0, m_ur = 0, m_lvl = 0, m_base = 0, m_acc = 0, m_old_hv = 0;
    logic [79:0] m_word = '0, m_hw = '0, m_old_hw = '0;
    int          m_k = 0, m_idx = 0;

    int          fs_cyc = 0, fs_cnt = 0, ur_cyc = 0, ur_cnt = 0, tog_cnt = 0;
    int          tog_t[$];
    logic        prev_ltc = 1'b0;

    task automatic m_start();
        m_base = m_lvl;
        m_word = m_old_hw;
        m_hv   = 0;
        m_k    = 0;
        m_run  = 1;
        m_fs   = 1;
    endtask

    // Model update on each edge, then compare and monitor away from the edge.
    always begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_run = 0; m_hv = 0; m_fs = 0; m_ur = 0; m_lvl = 0; m_idx = 0; m_k = 0;
        end else begin
            m_old_hv = m_hv;
            m_old_hw = m_hw;
            m_fs = 0;
            m_ur = 0;
            m_acc = tc_valid && !m_hv;
            if (m_run) m_k++;
            if (!m_run && m_old_hv) begin
                m_start();
            end else if (m_run && m_k == FRAME) begin
                if (m_old_hv) m_start();
                else begin
                    m_run = 0;
                    m_ur  = 1;
                end
            end
            if (m_run) begin
                m_lvl = level_at(m_word, m_base, m_k);
                m_idx = m_k / CELL;
            end
            if (m_acc) begin
                m_hv = 1;
                m_hw = tc_data;
            end
        end
        #1;
        check("ltc_out", ltc_out, m_lvl);
        check("frame_start", frame_start, m_fs);
        check("underrun", underrun, m_ur);
        check("busy", busy, m_run);
        check("bit_idx", bit_idx, m_idx);
        check("tc_ready", tc_ready, rst_n & ~m_hv);
        if (ltc_out !== prev_ltc) begin
            tog_cnt++;
            tog_t.push_back(cyc);
        end
        prev_ltc = ltc_out;
        if (frame_start) begin fs_cnt++; fs_cyc = cyc; end
        if (underrun)    begin ur_cnt++; ur_cyc = cyc; end
    end

    function automatic logic [79:0] rand_word();
        return {16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic clear_mon();
        tog_cnt = 0;
        tog_t.delete();
        fs_cnt = 0;
        ur_cnt = 0;
    endtask

    task automatic send(input logic [79:0] w, output int acc_at);
        int n;
        n = 0;
        acc_at = -1;
        @(negedge clk);
        tc_valid = 1'b1;
        tc_data  = w;
        while (!tc_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tc_ready) begin
            @(posedge clk);
            #2;
            acc_at = cyc;
        end else begin
            check("send_timeout", 0, 1);
        end
        @(negedge clk);
        tc_valid = 1'b0;
        tc_data  = rand_word();
    endtask

    task automatic wait_underrun();
        int n, u0;
        n = 0;
        u0 = ur_cnt;
        while (ur_cnt == u0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("underrun_timeout", ur_cnt != u0, 1);
    endtask

    task automatic wait_bit(input int b);
        int n;
        n = 0;
        while (!(busy && bit_idx == 7'(b)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("bit_wait_timeout", bit_idx, b);
    endtask

    task automatic spacing_check(input string name, input int gap);
        int bad;
        bad = 0;
        for (int i = 1; i < tog_t.size(); i++)
            if (tog_t[i] - tog_t[i-1] != gap) bad++;
        check(name, bad, 0);
    endtask

    int acc, a2, fs1, fsn, found;
    int exp4[6] = '{0, 4, 8, 16, 20, 24};
    logic [79:0] w;

    initial begin
        // Reset held with valid asserted: nothing may be accepted.
        tc_valid = 1'b1;
        tc_data  = 80'h1234;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", tc_ready, 0);
        check("rst_ltc", ltc_out, 0);
        check("rst_busy", busy, 0);
        rst_n    = 1'b1;
        tc_valid = 1'b0;
        #1;
        check("ready_after_rst", tc_ready, 1);
        repeat (5) @(negedge clk);
        check("no_frame_after_rst", fs_cnt, 0);

        // All-zero word: one toggle per cell.
        clear_mon();
        send(80'h0, acc);
        wait_underrun();
        check("s2_fs_latency", fs_cyc - acc, 1);
        check("s2_first_toggle", tog_t[0] - fs_cyc, 0);
        check("s2_toggles", tog_cnt, 80);
        check("s2_underrun_at", ur_cyc - fs_cyc, FRAME);
        spacing_check("s2_spacing", CELL);
        @(negedge clk);
        check("s2_busy_low", busy, 0);
        repeat (20) @(negedge clk);
        check("s2_stable", tog_cnt, 80);

        // All-ones word: two toggles per cell.
        clear_mon();
        w = '1;
        send(w, acc);
        wait_underrun();
        check("s3_toggles", tog_cnt, 160);
        spacing_check("s3_spacing", H);
        check("s3_underrun_at", ur_cyc - fs_cyc, FRAME);

        // Bits 1,0,1 then zeros.
        clear_mon();
        send(80'h5, acc);
        wait_underrun();
        for (int i = 1; i < 6; i++)
            check("s4_toggle_time", tog_t[i] - tog_t[0], exp4[i]);
        check("s4_toggles", tog_cnt, 82);

        // Second word queued mid-frame: seamless boundary.
        clear_mon();
        send(rand_word(), acc);
        wait_bit(10);
        fs1 = fs_cyc;
        send(rand_word(), a2);
        repeat (3) @(negedge clk);
        check("s5_ready_low", tc_ready, 0);
        begin
            int n;
            n = 0;
            while (fs_cnt < 2 && n < 3000) begin @(negedge clk); n++; end
        end
        check("s5_fs_count", fs_cnt, 2);
        check("s5_fs_spacing", fs_cyc - fs1, FRAME);
        check("s5_no_underrun", ur_cnt, 0);
        found = 0;
        foreach (tog_t[i]) if (tog_t[i] == fs_cyc) found = 1;
        check("s5_boundary_toggle", found, 1);
        check("s5_ready_back", tc_ready, 1);
        wait_underrun();
        check("s5_underrun_at", ur_cyc - fs_cyc, FRAME);

        // Reset mid-frame with a word queued.
        clear_mon();
        send(rand_word(), acc);
        wait_bit(5);
        send(rand_word(), a2);
        wait_bit(40);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("s6_ltc", ltc_out, 0);
        check("s6_busy", busy, 0);
        check("s6_ready", tc_ready, 1);
        check("s6_bit_idx", bit_idx, 0);
        fsn = fs_cnt;
        repeat (30) @(negedge clk);
        check("s6_hold_cleared", fs_cnt, fsn);
        send(rand_word(), acc);
        wait_underrun();
        check("s6_restart_latency", fs_cyc - acc, 1);
        check("s6_restart_len", ur_cyc - fs_cyc, FRAME);

        // Random words with random gaps.
        for (int i = 0; i < 8; i++) begin
            send(rand_word(), acc);
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(0, 800)) @(negedge clk);
        end
        begin
            int n;
            n = 0;
            while ((busy || !tc_ready) && n < 3000) begin @(negedge clk); n++; end
        end
        check("rand_drained", busy, 0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
